// File: rtl/ola_capture_if.sv
// ola_capture_if: valid/ready readout port carrying the captured {time,sample} window.
interface ola_capture_if #(
  parameter int sample_width = 4,
  parameter int time_width   = 32
);
  logic                    rd_valid;
  logic                    rd_ready;
  logic [sample_width-1:0] rd_sample;
  logic [time_width-1:0]   rd_time;
  logic                    rd_last;
  modport master (output rd_valid, rd_sample, rd_time, rd_last, input rd_ready);
  modport slave  (input rd_valid, rd_sample, rd_time, rd_last, output rd_ready);
endinterface

// File: rtl/ola_capture.sv
// ola_capture: ring-buffer capture of timestamped samples around a trigger, streamed out oldest first.
module ola_capture #(
  parameter int sample_width = 4,
  parameter int time_width   = 32,
  parameter int depth_width  = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    arm,
  input  logic                    abort,
  input  logic [depth_width-1:0]  post_count,
  input  logic                    in_valid,
  input  logic [sample_width-1:0] in_sample,
  input  logic [time_width-1:0]   in_time,
  input  logic                    in_trigger,
  output logic                    out_armed,
  output logic                    out_triggered,
  output logic                    out_done,
  ola_capture_if.master           rd
);
  localparam int depth = 2 ** depth_width;
  typedef enum logic [1:0] {IDLE, ARMED, POST, READOUT} state_t;
  state_t state, state_nx;
  logic [time_width+sample_width-1:0] mem [depth];
  logic [depth_width-1:0] wr_ptr, wr_ptr_nx, rd_ptr, rem;
  logic [depth_width:0]   fill, fill_nx, rd_cnt;
  logic start, wr_en, load, done;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = arm ? ARMED : IDLE;
      ARMED:   state_nx = !in_trigger ? ARMED : (rem == '0) ? READOUT : POST;
      POST:    state_nx = (in_valid && rem == depth_width'(1)) ? READOUT : POST;
      READOUT: state_nx = done ? IDLE : READOUT;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end
  // Pointer/fill next values also seed the readout start, so the final write is included.
  always_comb begin
    start     = state == IDLE && arm;
    wr_en     = in_valid && (state == ARMED || state == POST);
    wr_ptr_nx = start ? '0 : wr_ptr + depth_width'(wr_en);
    fill_nx   = start ? '0 : fill + (depth_width+1)'(wr_en && !fill[depth_width]);
    load      = state == READOUT && rd_cnt != '0 && (!rd.rd_valid || rd.rd_ready);
    done      = state == READOUT && (rd.rd_valid ? rd.rd_ready && rd.rd_last : rd_cnt == '0);
  end
  always_ff @(posedge clock)
    if (wr_en) mem[wr_ptr] <= {in_time, in_sample};
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr_ptr        <= '0;
      fill          <= '0;
      rem           <= '0;
      rd_ptr        <= '0;
      rd_cnt        <= '0;
      out_armed     <= 1'b0;
      out_triggered <= 1'b0;
      out_done      <= 1'b0;
      rd.rd_valid   <= 1'b0;
      rd.rd_last    <= 1'b0;
      rd.rd_sample  <= '0;
      rd.rd_time    <= '0;
    end else begin
      wr_ptr        <= wr_ptr_nx;
      fill          <= fill_nx;
      out_armed     <= state == ARMED;
      out_triggered <= state == POST;
      out_done      <= state == READOUT;
      if (start) rem <= post_count;
      else if (state == POST && in_valid) rem <= rem - depth_width'(1);
      if (state != READOUT) begin
        rd_ptr <= fill_nx[depth_width] ? wr_ptr_nx : '0;
        rd_cnt <= fill_nx;
      end else if (load) begin
        rd_ptr <= rd_ptr + depth_width'(1);
        rd_cnt <= rd_cnt - (depth_width+1)'(1);
      end
      if (abort || state != READOUT) begin
        rd.rd_valid <= 1'b0;
        rd.rd_last  <= 1'b0;
      end else if (load) begin
        rd.rd_valid  <= 1'b1;
        rd.rd_last   <= rd_cnt == (depth_width+1)'(1);
        rd.rd_sample <= mem[rd_ptr][sample_width-1:0];
        rd.rd_time   <= mem[rd_ptr][time_width+sample_width-1:sample_width];
      end else if (rd.rd_ready) begin
        rd.rd_valid <= 1'b0;
        rd.rd_last  <= 1'b0;
      end
    end
endmodule
